ddr_frame_reader: RTL and testbench

DDR_FRAME_READER -- requirements
Module: ddr_frame_reader

---
 rtl/ddr_frame_reader_pkg.sv | 17 +
 rtl/ddr_frame_reader_if.sv | 35 +++
 rtl/ddr_frame_reader.sv | 113 +++++++++++
 tb/tb_ddr_frame_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_frame_reader_pkg.sv
// Shared types and constants for the DDR frame reader: FSM encoding, read command code,
// per-command address step and data width.
package ddr_frame_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        CMD,
        DATA,
        DONE
    } rd_state_t;

    localparam logic [2:0]  RD_CMD    = 3'b001;
    localparam int unsigned ADDR_STEP = 8;
    localparam int unsigned DATA_W    = 128;

endpackage

// File: rtl/ddr_frame_reader_if.sv
// Arbiter, memory-controller and display-side signals of the frame reader.
// The master modport is the reader itself; slave is the surrounding system.
interface ddr_frame_reader_if
    import ddr_frame_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 28
) ();

    logic              rd_start;
    logic              rd_req;
    logic              rd_grant;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              user_rd_end;
    logic              frame_end;

    modport master (
        input  rd_start, rd_grant, app_rdy, app_rd_data, app_rd_data_valid,
        output rd_req, app_en, app_cmd, app_addr, rd_data, rd_data_valid,
               user_rd_end, frame_end
    );

    modport slave (
        output rd_start, rd_grant, app_rdy, app_rd_data, app_rd_data_valid,
        input  rd_req, app_en, app_cmd, app_addr, rd_data, rd_data_valid,
               user_rd_end, frame_end
    );

endinterface

// File: rtl/ddr_frame_reader.sv
// Reads a frame from DDR in BURST_LEN-word bursts, wrapping at the frame end; read data is
// forwarded with 1-cycle latency, commands hold while app_rdy is low, one request can queue.
module ddr_frame_reader
    import ddr_frame_reader_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FRAME_WORDS = 172800,
    parameter int unsigned FRAME_BASE  = 0,
    parameter int unsigned ADDR_W      = 28
) (
    input  logic               sclk,
    input  logic               rst,
    ddr_frame_reader_if.master bus
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(FRAME_BASE);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BURST_LEN);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_WORDS - 1);

    rd_state_t         state, state_nxt;
    logic              pending;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [CNT_W-1:0]  data_cnt;
    logic [IDX_W-1:0]  word_idx;
    logic [ADDR_W-1:0] addr;
    logic              frame_hit;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_data_valid_q;

    logic cmd_acc;
    logic enter_arb;
    logic fwd;
    logic data_in;

    assign cmd_acc   = (state == CMD) && bus.app_rdy;
    assign enter_arb = (state == IDLE) && (bus.rd_start || pending);
    assign data_in   = bus.app_rd_data_valid && (state inside {CMD, DATA});
    // Gate on the next state too, so a stray valid in the final DATA cycle never leaks into DONE.
    assign fwd       = (state inside {ARB, CMD, DATA}) && (state_nxt inside {ARB, CMD, DATA});

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.rd_start || pending) state_nxt = ARB;
            ARB:  if (bus.rd_grant) state_nxt = CMD;
            CMD: begin
                if (data_cnt == CNT_FULL) state_nxt = DONE;
                else if (cmd_acc && (cmd_cnt == CNT_LAST)) state_nxt = DATA;
            end
            DATA: if (data_cnt == CNT_FULL) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state           <= IDLE;
            pending         <= 1'b0;
            cmd_cnt         <= '0;
            data_cnt        <= '0;
            word_idx        <= '0;
            addr            <= BASE;
            frame_hit       <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state <= state_nxt;

            if (enter_arb) pending <= 1'b0;
            else if (bus.rd_start && (state != IDLE)) pending <= 1'b1;

            if (enter_arb) begin
                cmd_cnt   <= '0;
                data_cnt  <= '0;
                frame_hit <= 1'b0;
            end else begin
                if (cmd_acc) cmd_cnt <= cmd_cnt + CNT_W'(1);
                if (data_in && (data_cnt != CNT_FULL)) data_cnt <= data_cnt + CNT_W'(1);
                if (cmd_acc && (word_idx == IDX_LAST)) frame_hit <= 1'b1;
            end

            // The word index, not the address, decides the wrap back to the frame base.
            if (cmd_acc) begin
                if (word_idx == IDX_LAST) begin
                    word_idx <= '0;
                    addr     <= BASE;
                end else begin
                    word_idx <= word_idx + IDX_W'(1);
                    addr     <= addr + STEP;
                end
            end

            rd_data_valid_q <= fwd && bus.app_rd_data_valid;
            if (fwd) rd_data_q <= bus.app_rd_data;
        end
    end

    assign bus.rd_req        = (state != IDLE);
    assign bus.app_en        = (state == CMD);
    assign bus.app_cmd       = RD_CMD;
    assign bus.app_addr      = addr;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_data_valid_q;
    assign bus.user_rd_end   = (state == DONE);
    assign bus.frame_end     = (state == DONE) && frame_hit;

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Randomized scoreboard bench for ddr_frame_reader with a small DDR controller model.
module tb_ddr_frame_reader;

    localparam int BL   = 4;
    localparam int FW   = 8;
    localparam int BASE = 'h100;
    localparam int AW   = 28;

    logic sclk = 1'b0;
    logic rst;
    always #5 sclk = ~sclk;

    ddr_frame_reader_if #(.ADDR_W(AW)) bus ();

    ddr_frame_reader #(
        .BURST_LEN(BL), .FRAME_WORDS(FW), .FRAME_BASE(BASE), .ADDR_W(AW)
    ) dut (
        .sclk(sclk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(string name, int act, int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    endfunction

    // Scoreboard queues
    logic [AW-1:0]  exp_addr[$];
    logic [127:0]   exp_data[$];
    bit             exp_end[$];

    // Reference model: frame word pointer, addresses by plain arithmetic
    int wptr = 0;
    task automatic push_burst();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < BL; i++) begin
            exp_addr.push_back(AW'(BASE + 8 * wptr));
            if (wptr == FW - 1) hit = 1'b1;
            wptr = (wptr + 1) % FW;
        end
        exp_end.push_back(hit);
    endtask

    // Controller / arbiter model
    typedef struct { int due; logic [127:0] dat; } ret_t;
    ret_t ret_q[$];
    int   cyc = 0;
    int   last_due = 0;
    int   lat_min = 3;
    int   lat_max = 3;
    int   rdy_mode = 1;    // 0 low, 1 high, 2 random
    int   grant_mode = 1;  // 0 low, 1 high, 2 random
    bit   noise_en = 1'b0;
    bit   cmd_fire = 1'b0;

    initial begin
        ret_t r;
        int   due;
        bus.app_rdy           = 1'b0;
        bus.app_rd_data       = '0;
        bus.app_rd_data_valid = 1'b0;
        bus.rd_grant          = 1'b0;
        forever begin
            @(posedge sclk);
            #1;
            cyc++;
            if (rst) begin
                ret_q.delete();
                last_due = 0;
            end else if (cmd_fire) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                r.due = due;
                r.dat = {$urandom, $urandom, $urandom, $urandom};
                ret_q.push_back(r);
            end
            if (!rst && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data       = ret_q[0].dat;
                exp_data.push_back(ret_q[0].dat);
                ret_q.delete(0);
            end else begin
                bus.app_rd_data_valid = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
            end
            case (rdy_mode)
                0:       bus.app_rdy = 1'b0;
                1:       bus.app_rdy = 1'b1;
                default: bus.app_rdy = ($urandom_range(0, 3) != 0);
            endcase
            case (grant_mode)
                0:       bus.rd_grant = 1'b0;
                1:       bus.rd_grant = 1'b1;
                default: bus.rd_grant = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    int ends_seen = 0;
    int burst_vld = 0;
    int burst_acc = 0;
    int acc_cnt   = 0;
    bit prev_rdv  = 1'b0;

    initial begin
        forever begin
            @(negedge sclk);
            cmd_fire = bus.app_en && bus.app_rdy;
            if (cmd_fire) begin
                acc_cnt++;
                burst_acc++;
                if (exp_addr.size() == 0) fail("unexpected_cmd", int'(bus.app_addr), -1);
                else check("app_addr", bus.app_addr, exp_addr.pop_front());
                check("app_cmd", bus.app_cmd, 3'b001);
            end
            if (bus.rd_data_valid) begin
                burst_vld++;
                if (exp_data.size() == 0) fail("unexpected_rd_data_valid", 1, 0);
                else check("rd_data", bus.rd_data, exp_data.pop_front());
            end
            if (bus.user_rd_end) begin
                ends_seen++;
                check("end_after_last_vld", prev_rdv, 1'b1);
                check("burst_vld_cnt", burst_vld, BL);
                check("burst_cmd_cnt", burst_acc, BL);
                if (exp_end.size() == 0) fail("unexpected_user_rd_end", 1, 0);
                else check("frame_end", bus.frame_end, exp_end.pop_front());
                burst_vld = 0;
                burst_acc = 0;
            end else if (bus.frame_end) begin
                fail("frame_end_without_end", 1, 0);
            end
            prev_rdv = bus.rd_data_valid;
        end
    end

    task automatic pulse_start();
        @(posedge sclk);
        #1 bus.rd_start = 1'b1;
        @(posedge sclk);
        #1 bus.rd_start = 1'b0;
    endtask

    task automatic wait_ends(int target, int budget, string name);
        int n;
        n = 0;
        while (ends_seen < target && n < budget) begin
            @(posedge sclk);
            n++;
        end
        if (ends_seen < target) fail(name, ends_seen, target);
    endtask

    task automatic wait_acc(int target, string name);
        int n;
        n = 0;
        while (acc_cnt < target && n < 100) begin
            @(posedge sclk);
            n++;
        end
        if (acc_cnt < target) fail(name, acc_cnt, target);
    endtask

    task automatic wait_done_then_check_req(string name);
        int n;
        n = 0;
        @(negedge sclk);
        while (!bus.user_rd_end && n < 200) begin
            @(negedge sclk);
            n++;
        end
        if (!bus.user_rd_end) fail(name, 0, 1);
        @(negedge sclk);
        @(negedge sclk);
        check(name, bus.rd_req, 1'b1);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_rd_req"}, bus.rd_req, 1'b0);
        check({tag, "_app_en"}, bus.app_en, 1'b0);
        check({tag, "_rd_data_valid"}, bus.rd_data_valid, 1'b0);
        check({tag, "_user_rd_end"}, bus.user_rd_end, 1'b0);
        check({tag, "_frame_end"}, bus.frame_end, 1'b0);
        check({tag, "_rd_data"}, bus.rd_data, 128'h0);
        check({tag, "_app_addr"}, bus.app_addr, AW'(BASE));
    endtask

    initial begin
        int e0;
        int a0;
        int n;
        bus.rd_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        check_idle_outputs("reset");
        check("reset_app_cmd", bus.app_cmd, 3'b001);
        rst = 1'b0;

        // Scenario 1: full-speed burst, data 3 cycles after each command
        push_burst();
        pulse_start();
        wait_ends(1, 200, "s1_timeout");

        // Scenario 3a: second burst of the frame carries frame_end
        push_burst();
        pulse_start();
        wait_ends(2, 200, "s3_timeout");

        // Scenario 2 (and 3b restart at base): stall on the second command
        a0 = acc_cnt;
        push_burst();
        pulse_start();
        wait_acc(a0 + 1, "s2_first_cmd");
        rdy_mode = 0;
        @(negedge sclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            check("s2_hold_app_en", bus.app_en, 1'b1);
            check("s2_hold_app_addr", bus.app_addr, AW'('h108));
        end
        rdy_mode = 1;
        wait_ends(3, 200, "s2_timeout");

        // Scenario 4: two rd_start pulses mid-burst give one extra burst; then rd_start in DONE
        e0 = ends_seen;
        a0 = acc_cnt;
        push_burst();
        pulse_start();
        wait_acc(a0 + 1, "s4_first_cmd");
        rdy_mode = 0;
        push_burst();
        pulse_start();
        @(posedge sclk);
        pulse_start();
        rdy_mode = 1;
        wait_done_then_check_req("s4_rdreq_after_done");
        n = 0;
        while (!bus.user_rd_end && n < 200) begin
            @(negedge sclk);
            n++;
        end
        if (!bus.user_rd_end) fail("s4_second_done", 0, 1);
        push_burst();
        bus.rd_start = 1'b1;
        @(negedge sclk);
        bus.rd_start = 1'b0;
        @(negedge sclk);
        check("s4_done_start_rdreq", bus.rd_req, 1'b1);
        wait_ends(e0 + 3, 200, "s4_timeout");
        repeat (30) @(posedge sclk);
        @(negedge sclk);
        check("s4_burst_count", ends_seen, e0 + 3);
        check("s4_idle_rd_req", bus.rd_req, 1'b0);

        // Scenario 6: grant withheld for 10 cycles
        grant_mode = 0;
        e0 = ends_seen;
        push_burst();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge sclk);
            check("s6_rd_req", bus.rd_req, 1'b1);
            check("s6_app_en", bus.app_en, 1'b0);
        end
        grant_mode = 1;
        @(negedge sclk);
        check("s6_grant_seen_app_en", bus.app_en, 1'b0);
        @(negedge sclk);
        check("s6_cmd_after_grant", bus.app_en, 1'b1);
        wait_ends(e0 + 1, 200, "s6_timeout");

        // Scenario 5: reset after two data words
        e0 = ends_seen;
        push_burst();
        pulse_start();
        n = 0;
        while (burst_vld < 2 && n < 100) begin
            @(posedge sclk);
            n++;
        end
        if (burst_vld < 2) fail("s5_two_words", burst_vld, 2);
        @(negedge sclk);
        rst = 1'b1;
        @(negedge sclk);
        check_idle_outputs("s5_rst");
        rst = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        exp_end.delete();
        wptr      = 0;
        burst_vld = 0;
        burst_acc = 0;
        repeat (20) @(posedge sclk);
        @(negedge sclk);
        check("s5_no_user_rd_end", ends_seen, e0);
        push_burst();
        pulse_start();
        wait_ends(e0 + 1, 200, "s5_restart_timeout");

        // Randomized bursts: random ready, grant and latency, idle-time noise on the data valid
        rdy_mode   = 2;
        grant_mode = 2;
        lat_min    = 1;
        lat_max    = 4;
        for (int b = 0; b < 8; b++) begin
            noise_en = 1'b1;
            repeat (4) @(posedge sclk);
            noise_en = 1'b0;
            repeat (2) @(posedge sclk);
            e0 = ends_seen;
            push_burst();
            pulse_start();
            wait_ends(e0 + 1, 400, "rand_timeout");
        end

        repeat (10) @(posedge sclk);
        check("left_addr", exp_addr.size(), 0);
        check("left_data", exp_data.size(), 0);
        check("left_end", exp_end.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
